// File: rtl/controller_m.sv
// Eight-phase instruction sequencer for a simple accumulator CPU.
// Control outputs decode the current phase with the opcode and zero flag.
module controller_m (
    input  logic       clk,
    input  logic       rst_,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       mem_rd,
    output logic       load_ir,
    output logic       halt,
    output logic       inc_pc,
    output logic       load_ac,
    output logic       load_pc,
    output logic       mem_wr,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    phase_e phase_q, phase_d;
    logic   halted_q, halted_d;
    logic   aluop;
    logic   halt_now;

    assign aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);

    // Once halted, the sticky flag keeps the halt even if the opcode changes.
    assign halt_now = (phase_q == OP_ADDR) && (halted_q || (opcode == OP_HLT));

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        phase_d  = phase_e'(phase_q + 3'd1);
        halted_d = halted_q;
        if (halt_now) begin
            phase_d  = phase_q;
            halted_d = 1'b1;
        end
    end

    always_comb begin
        mem_rd  = 1'b0;
        load_ir = 1'b0;
        halt    = 1'b0;
        inc_pc  = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        mem_wr  = 1'b0;
        case (phase_q)
            INST_ADDR: ;
            INST_FETCH: mem_rd = 1'b1;
            INST_LOAD, IDLE: begin
                mem_rd  = 1'b1;
                load_ir = 1'b1;
            end
            OP_ADDR: begin
                halt   = halt_now;
                inc_pc = !halt_now;
            end
            OP_FETCH: mem_rd = aluop;
            ALU_OP: begin
                mem_rd  = aluop;
                load_ac = aluop;
                inc_pc  = (opcode == OP_SKZ) && zero;
                load_pc = (opcode == OP_JMP);
            end
            STORE: begin
                mem_rd  = aluop;
                load_ac = aluop;
                inc_pc  = (opcode == OP_JMP);
                load_pc = (opcode == OP_JMP);
                mem_wr  = (opcode == OP_STO);
            end
            default: ;
        endcase
    end

    assign phase = phase_q;

endmodule

// File: tb/tb_controller_m.sv
// Scoreboard bench for controller_m: a reference model queues the expected
// phase/control vector each cycle and the sampled DUT outputs are popped against it.
module tb_controller_m;

    logic       clk;
    logic       rst_;
    logic [2:0] opcode;
    logic       zero;
    logic       mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr;
    logic [2:0] phase;

    int n_chk  = 0;
    int n_pass = 0;

    logic [2:0] m_ph;
    logic       m_halt;
    logic [9:0] exp_q[$];

    controller_m dut (
        .clk     (clk),
        .rst_    (rst_),
        .opcode  (opcode),
        .zero    (zero),
        .mem_rd  (mem_rd),
        .load_ir (load_ir),
        .halt    (halt),
        .inc_pc  (inc_pc),
        .load_ac (load_ac),
        .load_pc (load_pc),
        .mem_wr  (mem_wr),
        .phase   (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector layout: {phase, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}
    function automatic logic [9:0] model(input logic [2:0] ph, input logic mh,
                                         input logic [2:0] op, input logic z);
        logic rd, ir, hl, inc, ac, pc, wr, alu;
        rd = 0; ir = 0; hl = 0; inc = 0; ac = 0; pc = 0; wr = 0;
        alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        case (ph)
            3'd1: rd = 1;
            3'd2, 3'd3: begin rd = 1; ir = 1; end
            3'd4: begin hl = (op == 3'd0) || mh; inc = !hl; end
            3'd5: rd = alu;
            3'd6: begin rd = alu; ac = alu; inc = (op == 3'd1) && z; pc = (op == 3'd7); end
            3'd7: begin rd = alu; ac = alu; inc = (op == 3'd7); pc = (op == 3'd7); wr = (op == 3'd6); end
            default: ;
        endcase
        return {ph, rd, ir, hl, inc, ac, pc, wr};
    endfunction

    task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", tag, got, exp);
    endtask

    function automatic logic [9:0] dut_vec();
        return {phase, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr};
    endfunction

    // Called at a negedge: drive, queue expectation, sample, then advance one clock.
    task automatic step(input logic [2:0] op, input logic z, input string tag);
        opcode = op;
        zero   = z;
        exp_q.push_back(model(m_ph, m_halt, op, z));
        #2;
        chk(tag, dut_vec(), exp_q.pop_front());
        chk({tag, "_rdwr"}, {9'd0, mem_rd & mem_wr}, 10'd0);
        chk({tag, "_irx"}, {9'd0, load_ir & (load_ac | load_pc | mem_wr)}, 10'd0);
        @(posedge clk);
        if (m_ph == 3'd4 && (op == 3'd0 || m_halt)) m_halt = 1'b1;
        else m_ph = m_ph + 3'd1;
        @(negedge clk);
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, holds across an edge, releases.
    task automatic pulse_reset(input string tag);
        #2;
        rst_ = 1'b0;
        m_ph = 3'd0;
        m_halt = 1'b0;
        #1;
        exp_q.push_back(model(m_ph, m_halt, opcode, zero));
        chk({tag, "_async"}, dut_vec(), exp_q.pop_front());
        @(posedge clk);
        #1;
        exp_q.push_back(model(m_ph, m_halt, opcode, zero));
        chk({tag, "_hold"}, dut_vec(), exp_q.pop_front());
        @(negedge clk);
        rst_ = 1'b1;
    endtask

    initial begin
        rst_   = 1'b0;
        opcode = 3'd0;
        zero   = 1'b0;
        m_ph   = 3'd0;
        m_halt = 1'b0;
        @(negedge clk);
        exp_q.push_back(model(3'd0, 1'b0, opcode, zero));
        chk("reset_state", dut_vec(), exp_q.pop_front());
        @(negedge clk);
        rst_ = 1'b1;

        for (int i = 0; i < 9; i++) step(3'd2, 1'b0, "add");
        for (int i = 0; i < 8; i++) step(3'd1, 1'b1, "skz_z1");
        for (int i = 0; i < 8; i++) step(3'd1, 1'b0, "skz_z0");
        for (int i = 0; i < 16; i++) step(3'd1, 1'($urandom_range(0, 1)), "skz_rndz");
        for (int i = 0; i < 8; i++) step(3'd7, 1'b1, "jmp");
        for (int i = 0; i < 8; i++) step(3'd6, 1'b0, "sto");
        for (int i = 0; i < 8; i++) step(3'd3, 1'b1, "and");
        for (int i = 0; i < 8; i++) step(3'd4, 1'b0, "xor");
        for (int i = 0; i < 8; i++) step(3'd5, 1'b1, "lda");
        for (int i = 0; i < 40; i++)
            step(3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)), "rand");

        // Walk to OP_ADDR, then trap on HLT.
        while (m_ph != 3'd4) step(3'd2, 1'b0, "pre_hlt");
        for (int i = 0; i < 22; i++) step(3'd0, 1'($urandom_range(0, 1)), "hlt");
        for (int i = 0; i < 6; i++) step(3'd2, 1'b1, "hlt_add");
        pulse_reset("hlt_rst");
        for (int i = 0; i < 9; i++) step(3'd2, 1'b0, "post_hlt");

        // Abort mid-sequence in ALU_OP with LDA.
        while (m_ph != 3'd6) step(3'd5, 1'b0, "pre_lda");
        opcode = 3'd5;
        exp_q.push_back(model(m_ph, m_halt, 3'd5, 1'b0));
        #1;
        chk("lda_aluop", dut_vec(), exp_q.pop_front());
        pulse_reset("lda_rst");
        for (int i = 0; i < 9; i++) step(3'd5, 1'b0, "post_lda");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
